// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl: UART frame serializer driving start, data (LSB first), optional parity and stop bits
// Ports:
//   CLK               baud-rate clock, rising edge
//   RST               asynchronous active-high reset, aborts any frame in progress
//   P_DATA            parallel word to send
//   Data_valid        send request, honoured only while Busy is low
//   PAR_EN            insert a parity bit (latched at accept)
//   PAR_BIT           parity bit supplied by the parity calculator
//   Frame_Data        latched copy of the accepted word, stable for the whole frame
//   Enable_Par_Output parity request, high in the last data-bit cycle of a parity frame
//   TX_OUT            registered serial line, idle high
//   Busy              registered, high for every bit of a frame
//   Frame_Done        high during the final stop-bit cycle
module uart_tx_frame_ctrl #(
    parameter int DATA_LENGTH = 8,
    parameter int STOP_BITS   = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DATA_LENGTH-1:0] P_DATA,
    input  logic                   Data_valid,
    input  logic                   PAR_EN,
    input  logic                   PAR_BIT,
    output logic [DATA_LENGTH-1:0] Frame_Data,
    output logic                   Enable_Par_Output,
    output logic                   TX_OUT,
    output logic                   Busy,
    output logic                   Frame_Done
);
    localparam int CW = $clog2(DATA_LENGTH);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_LENGTH - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 r_state;
    logic [DATA_LENGTH-1:0] r_shift;
    logic [DATA_LENGTH-1:0] r_frame;
    logic [CW-1:0]          r_cnt;
    logic                   r_par_en;
    logic                   r_tx;
    logic                   r_busy;
    logic                   w_last_data;

    assign w_last_data       = (r_state == DATA) && (r_cnt == LAST_DATA);
    assign Enable_Par_Output = w_last_data && r_par_en;
    assign Frame_Done        = (r_state == STOP) && (r_cnt == LAST_STOP);
    assign Frame_Data        = r_frame;
    assign TX_OUT            = r_tx;
    assign Busy              = r_busy;

    // The counter is cleared on leaving DATA rather than incremented, so it never wraps
    // and STOP starts counting from zero whether or not a parity bit was sent.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_frame  <= '0;
            r_cnt    <= '0;
            r_par_en <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (Data_valid) begin
                    r_frame  <= P_DATA;
                    r_shift  <= P_DATA;
                    r_par_en <= PAR_EN;
                    r_tx     <= 1'b0;
                    r_busy   <= 1'b1;
                    r_state  <= START;
                end
                START: begin
                    r_tx    <= r_shift[0];
                    r_cnt   <= '0;
                    r_state <= DATA;
                end
                DATA: begin
                    r_shift <= r_shift >> 1;
                    if (r_cnt == LAST_DATA) begin
                        r_cnt   <= '0;
                        r_tx    <= r_par_en ? PAR_BIT : 1'b1;
                        r_state <= r_par_en ? PARITY : STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_tx  <= r_shift[1];
                    end
                end
                PARITY: begin
                    r_tx    <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= STOP;
                end
                STOP: if (r_cnt == LAST_STOP) begin
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb_uart_tx_frame_ctrl: randomized self-checking bench for uart_tx_frame_ctrl (8N1 and 7-bit/2-stop builds)
module tb_uart_tx_frame_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] p_data = '0;
    logic       dv = 1'b0;
    logic       par_en = 1'b0;
    logic       par_bit = 1'b0;
    logic       sel = 1'b0;

    logic [7:0] a_fd;
    logic       a_ep, a_tx, a_busy, a_done;
    logic [6:0] b_fd;
    logic       b_ep, b_tx, b_busy, b_done;

    logic [7:0] fd_o;
    logic       ep_o, tx_o, busy_o, done_o;

    int n_checks = 0;
    int n_fail = 0;

    uart_tx_frame_ctrl #(.DATA_LENGTH(8), .STOP_BITS(1)) dut_a (
        .CLK(clk), .RST(rst), .P_DATA(p_data), .Data_valid(dv), .PAR_EN(par_en),
        .PAR_BIT(par_bit), .Frame_Data(a_fd), .Enable_Par_Output(a_ep), .TX_OUT(a_tx),
        .Busy(a_busy), .Frame_Done(a_done)
    );

    uart_tx_frame_ctrl #(.DATA_LENGTH(7), .STOP_BITS(2)) dut_b (
        .CLK(clk), .RST(rst), .P_DATA(p_data[6:0]), .Data_valid(dv), .PAR_EN(par_en),
        .PAR_BIT(par_bit), .Frame_Data(b_fd), .Enable_Par_Output(b_ep), .TX_OUT(b_tx),
        .Busy(b_busy), .Frame_Done(b_done)
    );

    assign fd_o   = sel ? {1'b0, b_fd} : a_fd;
    assign ep_o   = sel ? b_ep : a_ep;
    assign tx_o   = sel ? b_tx : a_tx;
    assign busy_o = sel ? b_busy : a_busy;
    assign done_o = sel ? b_done : a_done;

    always #5 clk = ~clk;

    task automatic check_idle(input string tag);
        n_checks += 3;
        if (tx_o !== 1'b1) begin n_fail++; $display("FAIL %s idle tx: got %b want 1", tag, tx_o); end
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL %s idle busy: got %b want 0", tag, busy_o); end
        if (done_o !== 1'b0) begin n_fail++; $display("FAIL %s idle done: got %b want 0", tag, done_o); end
    endtask

    // noise: 0 quiet inputs, 1 random inputs mid-frame, 2 Data_valid held with 8'hFF
    task automatic send_frame(input string tag, input logic [7:0] data, input logic pen,
                              input logic pbit, input int noise);
        int dl, sb, n;
        logic q[$];
        logic [7:0] fd_exp;
        dl = sel ? 7 : 8;
        sb = sel ? 2 : 1;
        fd_exp = sel ? {1'b0, data[6:0]} : data;
        q = {1'b0};
        for (int i = 0; i < dl; i++) q.push_back(data[i]);
        if (pen) q.push_back(pbit);
        for (int i = 0; i < sb; i++) q.push_back(1'b1);
        n = q.size();
        @(negedge clk);
        dv = 1'b1; p_data = data; par_en = pen; par_bit = pbit;
        @(negedge clk);
        dv = 1'b0;
        for (int i = 0; i < n; i++) begin
            n_checks += 5;
            if (tx_o !== q[i]) begin n_fail++; $display("FAIL %s tx bit %0d: got %b want %b", tag, i, tx_o, q[i]); end
            if (busy_o !== 1'b1) begin n_fail++; $display("FAIL %s busy bit %0d: got %b want 1", tag, i, busy_o); end
            if (done_o !== (i == n - 1)) begin n_fail++; $display("FAIL %s done bit %0d: got %b want %b", tag, i, done_o, i == n - 1); end
            if (ep_o !== (pen && i == dl)) begin n_fail++; $display("FAIL %s par_req bit %0d: got %b want %b", tag, i, ep_o, pen && i == dl); end
            if (fd_o !== fd_exp) begin n_fail++; $display("FAIL %s frame_data bit %0d: got %h want %h", tag, i, fd_o, fd_exp); end
            if (noise == 1) begin p_data = 8'($urandom); par_en = 1'($urandom); dv = 1'($urandom); end
            if (noise == 2) begin p_data = 8'hFF; dv = 1'b1; end
            @(negedge clk);
        end
        check_idle(tag);
        dv = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        check_idle("reset");
        n_checks += 2;
        if (fd_o !== 8'h00) begin n_fail++; $display("FAIL reset frame_data: got %h want 00", fd_o); end
        if (ep_o !== 1'b0) begin n_fail++; $display("FAIL reset par_req: got %b want 0", ep_o); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        send_frame("a5_no_par", 8'hA5, 1'b0, 1'b0, 0);
        send_frame("03_par", 8'h03, 1'b1, 1'b1, 0);
        send_frame("00_par0", 8'h00, 1'b1, 1'b0, 0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 20; k++)
            send_frame("random", 8'($urandom), 1'($urandom), 1'($urandom), 1);
    endtask

    task automatic test_ignore_busy;
        send_frame("ignore_ff", 8'h3C, 1'b0, 1'b0, 2);
        send_frame("ignore_ff_par", 8'h81, 1'b1, 1'b0, 2);
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        logic bit_exp;
        int m;
        d = 8'h55;
        @(negedge clk);
        dv = 1'b1; p_data = d; par_en = 1'b0;
        for (int k = 0; k < 44; k++) begin
            @(negedge clk);
            m = k % 11;
            bit_exp = (m == 0) ? 1'b0 : (m <= 8) ? d[m - 1] : 1'b1;
            n_checks += 3;
            if (tx_o !== bit_exp) begin n_fail++; $display("FAIL b2b tx cycle %0d: got %b want %b", k, tx_o, bit_exp); end
            if (busy_o !== (m < 10)) begin n_fail++; $display("FAIL b2b busy cycle %0d: got %b want %b", k, busy_o, m < 10); end
            if (done_o !== (m == 9)) begin n_fail++; $display("FAIL b2b done cycle %0d: got %b want %b", k, done_o, m == 9); end
        end
        dv = 1'b0;
        repeat (12) @(negedge clk);
        check_idle("b2b_end");
    endtask

    task automatic test_reset_mid_frame;
        @(negedge clk);
        dv = 1'b1; p_data = 8'hA5; par_en = 1'b0;
        @(negedge clk);
        dv = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (tx_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst bit4 tx: got %b want 0", tx_o); end
        #2 rst = 1'b1;
        #1;
        check_idle("mid_rst");
        n_checks++;
        if (fd_o !== 8'h00) begin n_fail++; $display("FAIL mid_rst frame_data: got %h want 00", fd_o); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_rst");
        send_frame("post_rst", 8'($urandom), 1'($urandom), 1'($urandom), 0);
    endtask

    task automatic test_two_stop;
        sel = 1'b1;
        send_frame("7e2_par", 8'h4B, 1'b1, 1'b1, 0);
        for (int k = 0; k < 8; k++)
            send_frame("7e2_random", 8'($urandom), 1'($urandom), 1'($urandom), 1);
        sel = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_directed;
        test_random;
        test_ignore_busy;
        test_back_to_back;
        test_reset_mid_frame;
        test_two_stop;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
